// File: rtl/inbuf_demux_pkg.sv
// Shared types and widths for the input-buffer demux. The global defines (DATAW, VCHW,
// INBUF_DEPTH) normally come from define.h; the guarded defaults below apply otherwise.
`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef INBUF_DEPTH
`define INBUF_DEPTH 4
`endif

package inbuf_demux_pkg;

  localparam int unsigned DataW    = `DATAW + 1;
  localparam int unsigned VchIdxW  = `VCHW + 1;
  localparam int unsigned DefDepth = `INBUF_DEPTH;

  typedef logic [DataW-1:0] flit_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO: one write port, one read port, occupancy count.
// Head flit is presented combinationally and forced to zero while empty.
module vc_fifo
  import inbuf_demux_pkg::*;
#(
  parameter int unsigned Depth = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [DataW-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [DataW-1:0]         rd_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  flit_t           mem_q [Depth];
  logic            push, pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  assign pop  = rd_en_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the write.
  assign push = wr_en_i & (~full_o | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/inbuf_demux.sv
// Router input buffer: demuxes incoming flits into per-VC FIFOs and returns credits on pops.
// Optional sticky overflow flag oerr is built only when INBUF_OVF_CHECK_EN is defined.
module inbuf_demux
  import inbuf_demux_pkg::*;
#(
  parameter int unsigned VCH   = 2,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [DataW-1:0]       idata,
  input  logic                   ivalid,
  input  logic [VchIdxW-1:0]     ivch,
  input  logic [VCH-1:0]         irdy,
  output logic [VCH*DataW-1:0]   odata,
  output logic [VCH-1:0]         oempty,
  output logic [VCH-1:0]         ocredit
`ifdef INBUF_OVF_CHECK_EN
  ,
  output logic                   oerr
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [VCH-1:0]  wr_en, pop, full, empty;
  logic [VCH-1:0]  credit_q;
  logic [CntW-1:0] count [VCH];

  for (genvar v = 0; v < VCH; v++) begin : g_vc
    assign wr_en[v] = ivalid && (ivch == VchIdxW'(v));
    assign pop[v]   = irdy[v] & ~empty[v];

    vc_fifo #(
      .Depth (DEPTH)
    ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (rst_),
      .wr_en_i   (wr_en[v]),
      .wr_data_i (idata),
      .rd_en_i   (irdy[v]),
      .rd_data_o (odata[v*DataW +: DataW]),
      .count_o   (count[v]),
      .full_o    (full[v]),
      .empty_o   (empty[v])
    );

    a_count_range : assert property (@(posedge clk) disable iff (!rst_)
      (count[v] <= CntW'(DEPTH)) && (full[v] == (count[v] == CntW'(DEPTH))));
  end

  assign oempty  = empty;
  assign ocredit = credit_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      credit_q <= '0;
    end else begin
      credit_q <= pop;
    end
  end

`ifdef INBUF_OVF_CHECK_EN
  logic drop;
  logic oerr_q;

  assign drop = ivalid & full[ivch] & ~pop[ivch];
  assign oerr = oerr_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      oerr_q <= 1'b0;
    end else if (drop) begin
      oerr_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_inbuf_demux.sv
// Directed bench for inbuf_demux: vector table for single-cycle behaviour plus
// hand-written sequences for overflow, full write+pop, pointer wrap and async reset.
`ifndef DATAW
`define DATAW 7
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef INBUF_DEPTH
`define INBUF_DEPTH 4
`endif

module tb_inbuf_demux;

  localparam int DW = `DATAW + 1;

  logic            clk = 1'b0;
  logic            rst_;
  logic [DW-1:0]   idata;
  logic            ivalid;
  logic [`VCHW:0]  ivch;
  logic [1:0]      irdy;
  logic [2*DW-1:0] odata;
  logic [1:0]      oempty;
  logic [1:0]      ocredit;
`ifdef INBUF_OVF_CHECK_EN
  logic            oerr;
`endif

  int total = 0;
  int bad   = 0;

  inbuf_demux #(
    .VCH   (2),
    .DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_    (rst_),
    .idata   (idata),
    .ivalid  (ivalid),
    .ivch    (ivch),
    .irdy    (irdy),
    .odata   (odata),
    .oempty  (oempty),
    .ocredit (ocredit)
`ifdef INBUF_OVF_CHECK_EN
    ,
    .oerr    (oerr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [`VCHW:0] ch;
    logic [DW-1:0] d;
    logic [1:0]    rdy;
    logic [1:0]    e_empty;
    logic [DW-1:0] e_d0;
    logic [DW-1:0] e_d1;
    logic [1:0]    e_cr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [`VCHW:0] ch, input logic [DW-1:0] d,
                       input logic [1:0] rdy);
    ivalid = v;
    ivch   = ch;
    idata  = d;
    irdy   = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 2'b00);
    #2 rst_ = 1'b0;
    #1;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  int credits;

  initial begin
    //            v   ch  data   rdy    empty  d0     d1     cr
    tbl[0]  = '{1'b1, 1'b1, 8'h5A, 2'b00, 2'b01, 8'h00, 8'h5A, 2'b00};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 2'b10, 2'b11, 8'h00, 8'h00, 2'b10};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 2'b00, 2'b11, 8'h00, 8'h00, 2'b00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 2'b11, 2'b11, 8'h00, 8'h00, 2'b00};
    tbl[4]  = '{1'b1, 1'b0, 8'h11, 2'b00, 2'b10, 8'h11, 8'h00, 2'b00};
    tbl[5]  = '{1'b1, 1'b1, 8'h22, 2'b00, 2'b00, 8'h11, 8'h22, 2'b00};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 2'b11, 2'b11, 8'h00, 8'h00, 2'b11};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 2'b00, 2'b11, 8'h00, 8'h00, 2'b00};
    tbl[8]  = '{1'b1, 1'b0, 8'h33, 2'b01, 2'b10, 8'h33, 8'h00, 2'b00};
    tbl[9]  = '{1'b1, 1'b0, 8'h44, 2'b01, 2'b10, 8'h44, 8'h00, 2'b01};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 2'b01, 2'b11, 8'h00, 8'h00, 2'b01};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 2'b00, 2'b11, 8'h00, 8'h00, 2'b00};

    rst_ = 1'b0;
    drive(1'b0, '0, '0, 2'b00);
    #2;
    check("reset_oempty", 32'(oempty), 32'h3);
    check("reset_odata", 32'(odata), 32'h0);
    check("reset_ocredit", 32'(ocredit), 32'h0);
`ifdef INBUF_OVF_CHECK_EN
    check("reset_oerr", 32'(oerr), 32'h0);
`endif
    @(negedge clk);
    rst_ = 1'b1;

    // Table vectors: row 0 is the first edge after reset release.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].rdy);
      step();
      check($sformatf("row%0d_oempty", i), 32'(oempty), 32'(tbl[i].e_empty));
      check($sformatf("row%0d_odata0", i), 32'(odata[DW-1:0]), 32'(tbl[i].e_d0));
      check($sformatf("row%0d_odata1", i), 32'(odata[2*DW-1:DW]), 32'(tbl[i].e_d1));
      check($sformatf("row%0d_ocredit", i), 32'(ocredit), 32'(tbl[i].e_cr));
    end

    // Overflow: fifth flit to a full VC0 is dropped.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, DW'(k), 2'b00);
      step();
      check($sformatf("ovf_fill%0d_head", k), 32'(odata[DW-1:0]), 32'h1);
    end
    drive(1'b1, 1'b0, 8'h05, 2'b00);
    step();
    check("ovf_drop_head", 32'(odata[DW-1:0]), 32'h1);
`ifdef INBUF_OVF_CHECK_EN
    check("ovf_oerr_set", 32'(oerr), 32'h1);
`endif
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_pop%0d_head", k), 32'(odata[DW-1:0]), 32'(k));
      drive(1'b0, 1'b0, '0, 2'b01);
      step();
      check($sformatf("ovf_pop%0d_credit", k), 32'(ocredit), 32'h1);
    end
    check("ovf_drained_empty", 32'(oempty[0]), 32'h1);
    check("ovf_drained_data", 32'(odata[DW-1:0]), 32'h0);
    step();
    check("ovf_extra_rdy_credit", 32'(ocredit), 32'h0);
`ifdef INBUF_OVF_CHECK_EN
    check("ovf_oerr_sticky", 32'(oerr), 32'h1);
`endif

    // Full VC0 with simultaneous write and pop.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, DW'(k * 16), 2'b00);
      step();
    end
    drive(1'b1, 1'b0, 8'h50, 2'b01);
    step();
    check("full_wp_head", 32'(odata[DW-1:0]), 32'h20);
    check("full_wp_credit", 32'(ocredit), 32'h1);
`ifdef INBUF_OVF_CHECK_EN
    check("full_wp_oerr", 32'(oerr), 32'h0);
`endif
    drive(1'b0, 1'b0, '0, 2'b01);
    for (int k = 3; k <= 5; k++) begin
      step();
      check($sformatf("full_wp_drain%0d", k), 32'(odata[DW-1:0]), 32'(k * 16));
    end
    step();
    check("full_wp_empty_after4", 32'(oempty[0]), 32'h1);

    // Pointer wrap on VC1: 10 flits, occupancy held at one.
    do_reset();
    credits = 0;
    drive(1'b1, 1'b1, 8'd100, 2'b00);
    step();
    credits += int'(ocredit[1]);
    check("wrap_first_head", 32'(odata[2*DW-1:DW]), 32'd100);
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b1, DW'(100 + k), 2'b10);
      step();
      credits += int'(ocredit[1]);
      check($sformatf("wrap_head%0d", k), 32'(odata[2*DW-1:DW]), 32'(100 + k));
    end
    drive(1'b0, 1'b1, '0, 2'b10);
    step();
    credits += int'(ocredit[1]);
    check("wrap_final_empty", 32'(oempty[1]), 32'h1);
    drive(1'b0, 1'b1, '0, 2'b00);
    step();
    credits += int'(ocredit[1]);
    check("wrap_credit_total", 32'(credits), 32'd10);

    // Asynchronous reset mid-cycle with 3 flits in VC0 and a credit pending.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, DW'(k), 2'b00);
      step();
    end
    drive(1'b0, 1'b0, '0, 2'b01);
    step();
    drive(1'b0, 1'b0, '0, 2'b00);
    check("arst_pre_credit", 32'(ocredit), 32'h1);
    check("arst_pre_empty", 32'(oempty), 32'h2);
    #3 rst_ = 1'b0;
    #1;
    check("arst_oempty", 32'(oempty), 32'h3);
    check("arst_odata", 32'(odata), 32'h0);
    check("arst_ocredit", 32'(ocredit), 32'h0);
    step();
    check("arst_held_credit", 32'(ocredit), 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("arst_post%0d_credit", k), 32'(ocredit), 32'h0);
      check($sformatf("arst_post%0d_empty", k), 32'(oempty), 32'h3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inbuf_demux.md
INBUF_DEMUX -- requirements
Module: inbuf_demux

Interface
REQ-001 SHALL have parameter VCH, default 2: number of virtual channels; must equal 2^(`VCHW+1).
REQ-002 SHALL have parameter DEPTH, default 4: flits per VC FIFO; power of two, >= 2.
REQ-003 SHALL have port clk  in  1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port idata  in  `DATAW+1: incoming flit from the upstream crossbar output.
REQ-006 SHALL have port ivalid  in  1: idata/ivch valid this cycle.
REQ-007 SHALL have port ivch  in  `VCHW+1: destination VC of the incoming flit.
REQ-008 SHALL have port irdy  in  VCH: per-VC dequeue strobe from the routing/allocation stage.
REQ-009 SHALL have port odata  out  VCH*(`DATAW+1): head flit per VC; VC v occupies slice v.
REQ-010 SHALL have port oempty  out  VCH: per-VC empty flag.
REQ-011 SHALL have port ocredit  out  VCH: per-VC one-cycle credit-return pulse to the upstream router.
REQ-012 SHALL have port oerr  out  1: sticky overflow flag; present only under INBUF_OVF_CHECK_EN.

Function
REQ-013 SHALL write idata into FIFO[ivch] on a rising edge when ivalid=1 and FIFO[ivch] is not full.
REQ-014 SHALL make a written flit visible on odata slice v with oempty[v]=0 in the cycle after the write edge, i.e. 1-cycle latency.
REQ-015 SHALL pop FIFO[v] on an edge with irdy[v]=1 and oempty[v]=0; irdy[v] on an empty FIFO SHALL be ignored, with no pop and no credit.
REQ-016 SHALL assert ocredit[v] for exactly one cycle, registered, in the cycle after each accepted pop of VC v.
REQ-017 SHALL, on a simultaneous write and pop of the same VC, perform both; occupancy is unchanged, including when the FIFO is full.
REQ-018 SHALL, on a write to a full FIFO without a pop, drop the flit and leave pointers and occupancy unchanged.
REQ-019 SHALL keep per-VC read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH, and an occupancy count of clog2(DEPTH)+1 bits in the range 0..DEPTH.
REQ-020 SHALL drive odata slice v to all zeros while oempty[v]=1.
REQ-021 SHALL operate the VCs independently; pops on several VCs in one cycle are all accepted.

Reset
REQ-022 SHALL, while rst_=0, clear all pointers and counts and drive oempty to all ones, ocredit to 0, odata to 0 and oerr to 0, regardless of clk.
REQ-023 SHALL discard FIFO contents on reset asserted mid-operation; no credits are emitted for discarded flits.
REQ-024 SHALL accept a write on the first rising edge after rst_ deasserts.

Configuration
REQ-025 SHALL, with INBUF_OVF_CHECK_EN defined, set oerr=1 on any REQ-018 drop; oerr stays 1 until reset.
REQ-026 SHALL, without INBUF_OVF_CHECK_EN, omit the oerr port and logic; drops per REQ-018 are unchanged.

Structure
REQ-027 SHALL take `DATAW, `VCHW and a new `INBUF_DEPTH default (4) from the shared define.h.
REQ-028 SHALL instantiate one sub-module, vc_fifo (1 write port, 1 read port, count, full/empty), VCH times, plus demux write-enable logic and credit registers.

Verification
REQ-029 SHALL have a bench check this case: after reset, ivalid=1, ivch=1, idata=0x5A. Next cycle: oempty=2'b01 and slice 1 = 0x5A. irdy=2'b10 pops it, and ocredit=2'b10 pulses for 1 cycle.
REQ-030 SHALL have a bench check this case: write 4 flits 1,2,3,4 to VC0 with DEPTH=4, then a 5th flit 5. Flit 5 is dropped, and oerr=1 with the macro. Popping four times yields 1,2,3,4, then oempty[0]=1.
REQ-031 SHALL have a bench check this case: VC0 full, then ivalid to VC0 together with irdy[0]=1 in the same cycle. Count stays 4, head advances, ocredit[0] pulses, and oerr stays 0.
REQ-032 SHALL have a bench check this case: irdy=2'b11 with both VCs empty. No pop and ocredit=0; then write VC0 and VC1 in consecutive cycles and pop both together, giving ocredit=2'b11 for one cycle.
REQ-033 SHALL have a bench check this case: pointer wrap over 10 write/pop pairs on VC1 with DEPTH=4. Data order is preserved and exactly 10 credits are returned.
REQ-034 SHALL have a bench check this case: rst_ pulled low mid-cycle with 3 flits in VC0. oempty becomes all ones immediately with no clock edge, and no ocredit is emitted.
